ex_hilo_mult: RTL and testbench
===============================

Name: ex_hilo_mult

Overview:
Execute-stage HI/LO unit. It sits directly downstream of the decode stage and consumes the decoded aluop and the reg1/reg2 operands for MULT, MULTU, MTHI, MTLO, MFHI and MFLO. It owns the architectural HI/LO registers and runs a 32-iteration radix-2 shift-add multiplier. It requests a pipeline stall while a multiply is in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; the iteration count equals DATA_W.
- ALUOP_W, 8, aluop bus width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- valid_i  in  1  an instruction is presented on aluop_i/reg1_i/reg2_i.
- aluop_i  in  ALUOP_W  decoded operation.
- reg1_i  in  DATA_W  rs operand (multiplicand; source for MTHI/MTLO).
- reg2_i  in  DATA_W  rt operand (multiplier).
- annul_i  in  1  abort the in-flight multiply (pipeline flush).
- stall_req_o  out  1  hold the upstream stages.
- mf_data_o  out  DATA_W  HI (MFHI) or LO (MFLO); 0 for any other op.
- hi_o  out  DATA_W  current HI register.
- lo_o  out  DATA_W  current LO register.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - hi_o = lo_o = 0. Counter, accumulator and operand registers cleared.
  - stall_req_o = 0, busy_o = 0, mf_data_o = 0.
  - Reset mid-multiply discards the operation; HI/LO = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, valid_i = 1:
  - MULT/MULTU:
    - stall_req_o = 1 combinationally in this same cycle.
    - At the edge, latch |reg1_i| and |reg2_i| (MULT: two's-complement magnitude; MULTU: raw values).
    - Also latch neg = reg1_i[31] ^ reg2_i[31] (MULT only; 0 for MULTU).
    - Clear the 64-bit accumulator and counter, then go to BUSY.
  - MTHI: hi <= reg1_i at the edge. MTLO: lo <= reg1_i. No stall.
  - MFHI: mf_data_o = hi (combinational). MFLO: mf_data_o = lo. No state change.
  - Any other op, or valid_i = 0: no action.
- BUSY:
  - stall_req_o = 1.
  - Each cycle: if multiplier bit 0 is set, acc += multiplicand << count. Then shift the multiplier right and increment the counter.
  - After DATA_W iterations (counter reaches DATA_W-1 and that iteration completes), go to DONE.
  - BUSY lasts exactly DATA_W cycles.
- DONE:
  - stall_req_o = 0, so upstream advances at the end of this cycle.
  - The inputs still show the same MULT. DONE ignores aluop_i and does not restart.
  - At the edge: {hi, lo} <= neg ? -acc : acc (64-bit negate). Then go to IDLE.
- Latency: issue cycle + 32 BUSY + 1 DONE = 34 cycles. stall_req_o is high for 33 of them. The new HI/LO is visible in the cycle after DONE.
- annul_i:
  - In BUSY or DONE: go to IDLE at the next edge; HI/LO unchanged; stall_req_o drops combinationally in that cycle.
  - In IDLE: suppresses the MULT/MTHI/MTLO side effects of the presented op.
  - rst has priority over annul_i.
- Boundary values:
  - signed 0x80000000 magnitude = 0x80000000, interpreted as unsigned.
  - Zero operands still take the full 32 cycles (no early exit).
  - All arithmetic is modulo 2^64.

Decomposition:
- Shared package (extend the existing defines): aluop codes
  - EXE_MFHI_OP = 8'h10, EXE_MTHI_OP = 8'h11, EXE_MFLO_OP = 8'h12, EXE_MTLO_OP = 8'h13
  - EXE_MULT_OP = 8'h18, EXE_MULTU_OP = 8'h19
- Also in the package: the FSM state encoding (2-bit) and the ZeroWord constant.
- Natural sub-module: mult_seq_core. It holds the shift-add datapath, the counter and a done pulse. The parent holds the FSM, the HI/LO registers and the MT/MF handling.

Test Plan:
- MULTU reg1 = 0xFFFFFFFF, reg2 = 0xFFFFFFFF -> stall high for 33 cycles, then HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT reg1 = 0xFFFFFFFE (-2), reg2 = 0x00000003 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- MTHI 0x12345678, then MFHI -> mf_data_o = 0x12345678 on the MFHI cycle, no stall. MTLO 0xA5A5A5A5, then MFLO -> 0xA5A5A5A5.
- MULT 7 × 6 with annul_i pulsed in BUSY cycle 10 -> IDLE next cycle, stall drops, HI/LO keep their prior values.
- rst asserted in BUSY cycle 20 -> next cycle: IDLE, HI = LO = 0, stall_req_o = 0.
- Two back-to-back MULTU (3×5, then 2×2) with inputs held during stall -> the first yields LO = 15. DONE does not retrigger. The second yields LO = 4 after another 34 cycles.

Source files
------------

// File: rtl/ex_hilo_mult_pkg.sv
// Shared execute-stage definitions: aluop codes, HI/LO unit widths,
// FSM encoding and small helpers.
package ex_hilo_mult_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 8;
    localparam int unsigned ACC_W   = 2 * DATA_W;
    localparam int unsigned CNT_W   = $clog2(DATA_W);

    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t EXE_MFHI_OP  = 8'h10;
    localparam aluop_t EXE_MTHI_OP  = 8'h11;
    localparam aluop_t EXE_MFLO_OP  = 8'h12;
    localparam aluop_t EXE_MTLO_OP  = 8'h13;
    localparam aluop_t EXE_MULT_OP  = 8'h18;
    localparam aluop_t EXE_MULTU_OP = 8'h19;

    localparam logic [DATA_W-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Architectural {HI, LO} pair as written back from a multiply.
    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // Two's-complement magnitude; the most negative value maps onto itself
    // and is then treated as unsigned by the multiplier.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/ex_hilo_mult_if.sv
// Decode-to-execute HI/LO unit bus: operands in, stall and HI/LO views out.
interface ex_hilo_mult_if;
    import ex_hilo_mult_pkg::*;

    logic              valid_i;
    aluop_t            aluop_i;
    logic [DATA_W-1:0] reg1_i;
    logic [DATA_W-1:0] reg2_i;
    logic              annul_i;
    logic              stall_req_o;
    logic [DATA_W-1:0] mf_data_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              busy_o;

    modport master (
        output valid_i, aluop_i, reg1_i, reg2_i, annul_i,
        input  stall_req_o, mf_data_o, hi_o, lo_o, busy_o
    );

    modport slave (
        input  valid_i, aluop_i, reg1_i, reg2_i, annul_i,
        output stall_req_o, mf_data_o, hi_o, lo_o, busy_o
    );

endinterface

// File: rtl/ex_hilo_mult_mult_seq_core.sv
// Radix-2 shift-add unsigned multiplier datapath: one partial product per
// step, DATA_W steps per product. Sequencing is owned by the parent FSM.
module ex_hilo_mult_mult_seq_core
    import ex_hilo_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand_in,
    input  logic [DATA_W-1:0] mplier_in,
    output logic [ACC_W-1:0]  product,
    output logic              done_c
);

    logic [ACC_W-1:0]  mcand;
    logic [DATA_W-1:0] mplier;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    // Operand load, then per step: conditional add of the pre-shifted
    // multiplicand (equal to multiplicand << cnt), shift, count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= ACC_W'(mcand_in);
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign product = acc;
    assign done_c  = step && (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/ex_hilo_mult.sv
// Execute-stage HI/LO unit: owns HI/LO, serves MTHI/MTLO/MFHI/MFLO and
// sequences MULT/MULTU through the shift-add core while stalling upstream.
module ex_hilo_mult
    import ex_hilo_mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_hilo_mult_if.slave bus
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              neg;

    logic              is_mul;
    logic              is_signed;
    logic              issue;
    logic              mul_load;
    logic              mul_step;
    logic              mul_done_c;
    logic              hi_we;
    logic              lo_we;
    logic              wb;
    logic [ACC_W-1:0]  product;
    hilo_t             result;
    logic [DATA_W-1:0] mcand_in;
    logic [DATA_W-1:0] mplier_in;

    assign is_signed = (bus.aluop_i == EXE_MULT_OP);
    assign is_mul    = is_signed || (bus.aluop_i == EXE_MULTU_OP);
    assign issue     = bus.valid_i && !bus.annul_i && is_mul;

    assign mcand_in  = is_signed ? magnitude(bus.reg1_i) : bus.reg1_i;
    assign mplier_in = is_signed ? magnitude(bus.reg2_i) : bus.reg2_i;
    assign result    = neg ? hilo_t'(-product) : hilo_t'(product);

    ex_hilo_mult_mult_seq_core u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  (mcand_in),
        .mplier_in (mplier_in),
        .product   (product),
        .done_c    (mul_done_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; DONE always returns to IDLE so a held MULT cannot restart.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (issue) state_next = ST_BUSY;
            ST_BUSY: begin
                if (bus.annul_i) begin
                    state_next = ST_IDLE;
                end else if (mul_done_c) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Stall, MF read mux and per-state strobes; annul suppresses side effects.
    always_comb begin
        bus.stall_req_o = 1'b0;
        bus.busy_o      = (state != ST_IDLE);
        bus.mf_data_o   = ZeroWord;
        mul_load        = 1'b0;
        mul_step        = 1'b0;
        hi_we           = 1'b0;
        lo_we           = 1'b0;
        wb              = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    case (bus.aluop_i)
                        EXE_MFHI_OP: bus.mf_data_o = hi;
                        EXE_MFLO_OP: bus.mf_data_o = lo;
                        EXE_MTHI_OP: hi_we = !bus.annul_i;
                        EXE_MTLO_OP: lo_we = !bus.annul_i;
                        EXE_MULT_OP, EXE_MULTU_OP: begin
                            bus.stall_req_o = !bus.annul_i;
                            mul_load        = !bus.annul_i;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                bus.stall_req_o = !bus.annul_i;
                mul_step        = !bus.annul_i;
            end
            ST_DONE: wb = !bus.annul_i;
            default: ;
        endcase
    end

    // Sign capture at issue and HI/LO updates from MT ops or multiply writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi  <= ZeroWord;
            lo  <= ZeroWord;
            neg <= 1'b0;
        end else begin
            if (mul_load) begin
                neg <= is_signed && (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1]);
            end
            if (wb) begin
                hi <= result.hi;
                lo <= result.lo;
            end else begin
                if (hi_we) hi <= bus.reg1_i;
                if (lo_we) lo <= bus.reg1_i;
            end
        end
    end

    assign bus.hi_o = hi;
    assign bus.lo_o = lo;

endmodule

// File: tb/tb_ex_hilo_mult.sv
// Directed bench for the HI/LO unit with hand-computed expectations.
module tb_ex_hilo_mult;
    import ex_hilo_mult_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_hilo_mult_if bus_if ();

    ex_hilo_mult dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        bus_if.valid_i = 1'b1;
        bus_if.aluop_i = op;
        bus_if.reg1_i  = a;
        bus_if.reg2_i  = b;
    endtask

    // Issue a multiply and hold it until the DONE cycle; count stalled cycles.
    task automatic run_mul(input string tag, input aluop_t op,
                           input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        drive(op, a, b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus_if.stall_req_o) break;
            n++;
        end
        chk({tag, " stall_cycles"}, 64'(n), 64'd33);
        chk({tag, " done_busy"}, 64'(bus_if.busy_o), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus_if.valid_i = 1'b0;
        @(negedge clk);
        chk({tag, " hi"}, 64'(bus_if.hi_o), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus_if.lo_o), 64'(exp_lo));
        chk({tag, " busy"}, 64'(bus_if.busy_o), 64'd0);
        chk({tag, " stall"}, 64'(bus_if.stall_req_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus_if.valid_i = 1'b0;
        bus_if.aluop_i = '0;
        bus_if.reg1_i  = '0;
        bus_if.reg2_i  = '0;
        bus_if.annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset hi", 64'(bus_if.hi_o), 64'd0);
        chk("reset lo", 64'(bus_if.lo_o), 64'd0);
        chk("reset stall", 64'(bus_if.stall_req_o), 64'd0);
        chk("reset busy", 64'(bus_if.busy_o), 64'd0);
        chk("reset mf", 64'(bus_if.mf_data_o), 64'd0);
        @(posedge clk); #1;

        // Multiplies
        run_mul("multu_max", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle_check("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        run_mul("mult_m2x3", EXE_MULT_OP, 32'hFFFF_FFFE, 32'h0000_0003);
        idle_check("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_mul("mult_min", EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000);
        idle_check("mult_min", 32'h4000_0000, 32'h0000_0000);
        run_mul("mult_negneg", EXE_MULT_OP, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
        idle_check("mult_negneg", 32'h0000_0000, 32'h0000_002A);
        run_mul("multu_msb", EXE_MULTU_OP, 32'h8000_0000, 32'h0000_0002);
        idle_check("multu_msb", 32'h0000_0001, 32'h0000_0000);
        run_mul("multu_zero", EXE_MULTU_OP, 32'h0000_0000, 32'h1234_5678);
        idle_check("multu_zero", 32'h0000_0000, 32'h0000_0000);

        // MTHI / MFHI, MTLO / MFLO
        drive(EXE_MTHI_OP, 32'h1234_5678, 32'h0);
        @(negedge clk);
        chk("mthi stall", 64'(bus_if.stall_req_o), 64'd0);
        @(posedge clk); #1;
        drive(EXE_MFHI_OP, 32'h0, 32'h0);
        @(negedge clk);
        chk("mfhi data", 64'(bus_if.mf_data_o), 64'h1234_5678);
        chk("mfhi stall", 64'(bus_if.stall_req_o), 64'd0);
        @(posedge clk); #1;
        drive(EXE_MTLO_OP, 32'hA5A5_A5A5, 32'h0);
        @(posedge clk); #1;
        drive(EXE_MFLO_OP, 32'h0, 32'h0);
        @(negedge clk);
        chk("mflo data", 64'(bus_if.mf_data_o), 64'hA5A5_A5A5);
        @(posedge clk); #1;
        drive(8'h00, 32'h0, 32'h0);
        @(negedge clk);
        chk("other op mf", 64'(bus_if.mf_data_o), 64'd0);
        @(posedge clk); #1;

        // Annul in IDLE suppresses MTHI and MULT
        drive(EXE_MTHI_OP, 32'hDEAD_BEEF, 32'h0);
        bus_if.annul_i = 1'b1;
        @(posedge clk); #1;
        bus_if.annul_i = 1'b0;
        drive(EXE_MFHI_OP, 32'h0, 32'h0);
        @(negedge clk);
        chk("annul mthi", 64'(bus_if.mf_data_o), 64'h1234_5678);
        @(posedge clk); #1;
        drive(EXE_MULT_OP, 32'd7, 32'd6);
        bus_if.annul_i = 1'b1;
        @(negedge clk);
        chk("annul idle stall", 64'(bus_if.stall_req_o), 64'd0);
        @(posedge clk); #1;
        bus_if.annul_i = 1'b0;
        bus_if.valid_i = 1'b0;
        @(negedge clk);
        chk("annul idle busy", 64'(bus_if.busy_o), 64'd0);
        @(posedge clk); #1;

        // Annul in BUSY cycle 10
        drive(EXE_MULT_OP, 32'd7, 32'd6);
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        bus_if.annul_i = 1'b1;
        @(negedge clk);
        chk("annul busy stall", 64'(bus_if.stall_req_o), 64'd0);
        chk("annul busy busy", 64'(bus_if.busy_o), 64'd1);
        @(posedge clk); #1;
        bus_if.annul_i = 1'b0;
        idle_check("annul busy", 32'h1234_5678, 32'hA5A5_A5A5);

        // Back-to-back MULTU, inputs held through the stall
        run_mul("b2b_first", EXE_MULTU_OP, 32'd3, 32'd5);
        bus_if.reg1_i = 32'd2;
        bus_if.reg2_i = 32'd2;
        #1;
        chk("b2b first lo", 64'(bus_if.lo_o), 64'd15);
        chk("b2b no retrigger", 64'(bus_if.busy_o), 64'd0);
        chk("b2b second issue stall", 64'(bus_if.stall_req_o), 64'd1);
        run_mul("b2b_second", EXE_MULTU_OP, 32'd2, 32'd2);
        idle_check("b2b_second", 32'h0, 32'd4);

        // Reset in BUSY cycle 20
        drive(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("rst busy", 32'h0, 32'h0);
        repeat (40) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst busy no late wb", 64'(bus_if.lo_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
